// File: rtl/tqv_intercal_alu_host.sv
// TinyQV peripheral-port initiator for the INTERCAL ALU: writes A and B,
// reads the selected result, returns it (or a timeout error) to the caller.
module tqv_intercal_alu_host #(
    parameter int unsigned TIMEOUT        = 15,
    parameter bit          SKIP_REDUNDANT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    input  logic        data_ready
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WR_A, WR_B, RD, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] sha_q, sha_d, shb_q, shb_d;
    logic        va_q, va_d, vb_q, vb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  wn_q, wn_d, rn_q, rn_d;

    logic skip_a, skip_b;
    logic go_wa, go_wb, go_rd, go_idle;

    assign skip_a = SKIP_REDUNDANT && va_q && (sha_q == a_q);
    assign skip_b = SKIP_REDUNDANT && vb_q && (shb_q == b_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        va_d    = va_q;
        vb_d    = vb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wn_d    = wn_q;
        rn_d    = rn_q;
        go_wa   = 1'b0;
        go_wb   = 1'b0;
        go_rd   = 1'b0;
        go_idle = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!skip_a) begin
                    go_wa = 1'b1;
                end else if (!skip_b) begin
                    go_wb = 1'b1;
                end else begin
                    go_rd = 1'b1;
                end
            end
            WR_A: begin
                sha_d = a_q;
                va_d  = 1'b1;
                if (!skip_b) begin
                    go_wb = 1'b1;
                end else begin
                    go_rd = 1'b1;
                end
            end
            WR_B: begin
                shb_d = b_q;
                vb_d  = 1'b1;
                go_rd = 1'b1;
            end
            RD: begin
                // a strobe on the expiry edge still counts as success
                if (data_ready) begin
                    rdata_d = data_in;
                    rerr_d  = 1'b0;
                    go_idle = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = 32'h0;
                    rerr_d  = 1'b1;
                    go_idle = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                go_idle = 1'b1;
            end
        endcase

        unique case (1'b1)
            go_wa: begin
                addr_d  = 6'h00;
                dout_d  = a_q;
                wn_d    = 2'b10;
                rn_d    = 2'b11;
                state_d = WR_A;
            end
            go_wb: begin
                addr_d  = 6'h04;
                dout_d  = b_q;
                wn_d    = 2'b10;
                rn_d    = 2'b11;
                state_d = WR_B;
            end
            go_rd: begin
                addr_d  = {op_q, 2'b00};
                wn_d    = 2'b11;
                rn_d    = 2'b10;
                cnt_d   = 8'd0;
                state_d = RD;
            end
            go_idle: begin
                wn_d = 2'b11;
                rn_d = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            sha_q   <= 32'h0;
            shb_q   <= 32'h0;
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            rerr_q  <= 1'b0;
            addr_q  <= 6'h00;
            dout_q  <= 32'h0;
            wn_q    <= 2'b11;
            rn_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wn_q    <= wn_d;
            rn_q    <= rn_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rdata_q;
    assign rsp_err      = rerr_q;
    assign address      = addr_q;
    assign data_out     = dout_q;
    assign data_write_n = wn_q;
    assign data_read_n  = rn_q;

endmodule
